// File: rtl/vga_pkg.sv
// vga_pkg: shared timing defaults, phase encoding and pipeline flag bundle
// for the VGA scan engine.
//   - *_DEF localparams : 640x480@60 timing and default colour depth
//   - phase_t           : per-axis phase, in scan order
//   - pixFlags_t        : per-pixel flags carried alongside the fetch latency
package vga_pkg;

    localparam int COLOR_W_DEF = 4;

    localparam int H_SYNC_DEF  = 96;
    localparam int H_BP_DEF    = 48;
    localparam int H_ACT_DEF   = 640;
    localparam int H_FP_DEF    = 16;

    localparam int V_SYNC_DEF  = 2;
    localparam int V_BP_DEF    = 33;
    localparam int V_ACT_DEF   = 480;
    localparam int V_FP_DEF    = 10;

    localparam int CNT_W   = 12;   // wide enough for any sane total per axis
    localparam int COORD_W = 10;
    localparam int ADDR_W  = 20;

    typedef enum logic [1:0] {
        SYNC,
        BP,
        ACT,
        FP
    } phase_t;

    typedef struct packed {
        logic act;
        logic hSync;
        logic vSync;
    } pixFlags_t;

endpackage

// File: rtl/vga_scan_engine_if.sv
// vga_scan_engine_if: pixel fetch bus between the scan engine and the
// pixel source (frame buffer, pattern generator, ...).
//   oReq/oCoord_X/oCoord_Y/oAddress : fetch request, engine -> source
//   iRed/iGreen/iBlue               : pixel data, source -> engine,
//                                     returned a fixed latency after oReq
// Modports: master (engine side), slave (source side).
interface vga_scan_engine_if #(
    parameter int COLOR_W = vga_pkg::COLOR_W_DEF
);
    import vga_pkg::*;

    logic                 oReq;
    logic [COORD_W-1:0]   oCoord_X;
    logic [COORD_W-1:0]   oCoord_Y;
    logic [ADDR_W-1:0]    oAddress;
    logic [COLOR_W-1:0]   iRed;
    logic [COLOR_W-1:0]   iGreen;
    logic [COLOR_W-1:0]   iBlue;

    modport master (
        output oReq, oCoord_X, oCoord_Y, oAddress,
        input  iRed, iGreen, iBlue
    );

    modport slave (
        input  oReq, oCoord_X, oCoord_Y, oAddress,
        output iRed, iGreen, iBlue
    );

endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one scan axis (horizontal or vertical).
// Counts 0..TOTAL-1 on iAdvance and decodes the current phase.
//   iCLK, iRST_N : clock, async active-low reset
//   iAdvance     : count enable (1 for horizontal, line wrap for vertical)
//   oCont        : current count
//   oPhase       : SYNC / BP / ACT / FP for the current count
//   oWrap        : this advance takes the count from TOTAL-1 back to 0
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int LEN_SYNC = H_SYNC_DEF,
    parameter int LEN_BP   = H_BP_DEF,
    parameter int LEN_ACT  = H_ACT_DEF,
    parameter int LEN_FP   = H_FP_DEF
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iAdvance,
    output logic [CNT_W-1:0] oCont,
    output phase_t           oPhase,
    output logic             oWrap
);

    localparam int TOTAL = LEN_SYNC + LEN_BP + LEN_ACT + LEN_FP;
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] BP_START  = CNT_W'(LEN_SYNC);
    localparam logic [CNT_W-1:0] ACT_START = CNT_W'(LEN_SYNC + LEN_BP);
    localparam logic [CNT_W-1:0] FP_START  = CNT_W'(LEN_SYNC + LEN_BP + LEN_ACT);

    logic [CNT_W-1:0] cont;

    assign oCont = cont;
    assign oWrap = iAdvance && (cont == LAST);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)       cont <= '0;
        else if (oWrap)    cont <= '0;
        else if (iAdvance) cont <= cont + 1'b1;
    end

    always_comb begin
        oPhase = FP;
        if (cont < BP_START)       oPhase = SYNC;
        else if (cont < ACT_START) oPhase = BP;
        else if (cont < FP_START)  oPhase = ACT;
    end

endmodule

// File: rtl/vga_scan_engine.sv
// vga_scan_engine: VGA raster timing generator with a latency-compensated
// pixel fetch port.
//   iCLK, iRST_N        : pixel clock, async active-low reset
//   pix (master)        : fetch request (oReq, scaled coords, linear address)
//                         and returned colour PIX_LAT clocks later
//   oVGA_R/G/B          : registered colour, zero outside the active window
//   oVGA_H/V_SYNC       : syncs, asserted level SYNC_POL
//   oVGA_BLANK          : high only while active video is on the pins
//   oFrame/Line_Start   : one-cycle pulses, one clock after counters hit 0
// Optional build macro VGA_SCAN_CURSOR_EN adds iCursor_* ports and a
// 3-pixel-wide crosshair overlay in scaled coordinates.
module vga_scan_engine
    import vga_pkg::*;
#(
    parameter int COLOR_W     = COLOR_W_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BP        = H_BP_DEF,
    parameter int H_ACT       = H_ACT_DEF,
    parameter int H_FP        = H_FP_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BP        = V_BP_DEF,
    parameter int V_ACT       = V_ACT_DEF,
    parameter int V_FP        = V_FP_DEF,
    parameter bit SYNC_POL    = 1'b0,
    parameter int PIX_LAT     = 2,
    parameter int SCALE_SHIFT = 0
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    vga_scan_engine_if.master   pix,
`ifdef VGA_SCAN_CURSOR_EN
    input  logic                iCursor_EN,
    input  logic [COORD_W-1:0]  iCursor_X,
    input  logic [COORD_W-1:0]  iCursor_Y,
    input  logic [COLOR_W-1:0]  iCursor_R,
    input  logic [COLOR_W-1:0]  iCursor_G,
    input  logic [COLOR_W-1:0]  iCursor_B,
`endif
    output logic [COLOR_W-1:0]  oVGA_R,
    output logic [COLOR_W-1:0]  oVGA_G,
    output logic [COLOR_W-1:0]  oVGA_B,
    output logic                oVGA_H_SYNC,
    output logic                oVGA_V_SYNC,
    output logic                oVGA_BLANK,
    output logic                oFrame_Start,
    output logic                oLine_Start
);

    // ---------------- raster counters ----------------
    logic [CNT_W-1:0] hCont, vCont;
    phase_t           hPhase, vPhase;
    logic             hWrap, vWrapUnused;

    vga_axis_counter #(
        .LEN_SYNC(H_SYNC), .LEN_BP(H_BP), .LEN_ACT(H_ACT), .LEN_FP(H_FP)
    ) uHoriz (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .iAdvance(1'b1),
        .oCont   (hCont),
        .oPhase  (hPhase),
        .oWrap   (hWrap)
    );

    vga_axis_counter #(
        .LEN_SYNC(V_SYNC), .LEN_BP(V_BP), .LEN_ACT(V_ACT), .LEN_FP(V_FP)
    ) uVert (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .iAdvance(hWrap),
        .oCont   (vCont),
        .oPhase  (vPhase),
        .oWrap   (vWrapUnused)
    );

    // ---------------- fetch request ----------------
    logic               activeNow;
    logic [CNT_W-1:0]   hOff, vOff;
    logic [COORD_W-1:0] coordX, coordY;

    assign activeNow = (hPhase == ACT) && (vPhase == ACT);
    assign hOff      = hCont - CNT_W'(H_SYNC + H_BP);
    assign vOff      = vCont - CNT_W'(V_SYNC + V_BP);

    // Coordinates are held at zero between requests so the bus is quiet.
    assign coordX = activeNow ? COORD_W'(hOff >> SCALE_SHIFT) : '0;
    assign coordY = activeNow ? COORD_W'(vOff >> SCALE_SHIFT) : '0;

    assign pix.oReq     = activeNow;
    assign pix.oCoord_X = coordX;
    assign pix.oCoord_Y = coordY;
    assign pix.oAddress = ADDR_W'(coordY) * ADDR_W'(H_ACT >> SCALE_SHIFT)
                        + ADDR_W'(coordX);

    // ---------------- latency-matching delay line ----------------
    // Stage k holds the flags of the request issued k clocks ago, so the
    // last stage lines up with the data the source returns this cycle.
    pixFlags_t flagsNow, flagsOut;
    pixFlags_t flagPipe [1:PIX_LAT];

    assign flagsNow.act   = activeNow;
    assign flagsNow.hSync = (hPhase == SYNC);
    assign flagsNow.vSync = (vPhase == SYNC);
    assign flagsOut       = flagPipe[PIX_LAT];

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 1; i <= PIX_LAT; i++) flagPipe[i] <= '0;
        end else begin
            flagPipe[1] <= flagsNow;
            for (int i = 2; i <= PIX_LAT; i++) flagPipe[i] <= flagPipe[i-1];
        end
    end

`ifdef VGA_SCAN_CURSOR_EN
    // Crosshair: any pixel within one scaled pixel of the cursor column or
    // row. One extra bit keeps the +1 from wrapping at the coordinate edge.
    localparam logic [COORD_W:0] ONE_X = (COORD_W+1)'(1);
    logic [COORD_W:0] xExt, yExt, curXExt, curYExt;
    logic             hitX, hitY, cursorNow, cursorOut;
    logic             curPipe [1:PIX_LAT];

    assign xExt    = {1'b0, coordX};
    assign yExt    = {1'b0, coordY};
    assign curXExt = {1'b0, iCursor_X};
    assign curYExt = {1'b0, iCursor_Y};
    assign hitX    = (xExt + ONE_X >= curXExt) && (xExt <= curXExt + ONE_X);
    assign hitY    = (yExt + ONE_X >= curYExt) && (yExt <= curYExt + ONE_X);
    assign cursorNow = iCursor_EN && activeNow && (hitX || hitY);
    assign cursorOut = curPipe[PIX_LAT];

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 1; i <= PIX_LAT; i++) curPipe[i] <= 1'b0;
        end else begin
            curPipe[1] <= cursorNow;
            for (int i = 2; i <= PIX_LAT; i++) curPipe[i] <= curPipe[i-1];
        end
    end
`endif

    // ---------------- output stage ----------------
    logic [COLOR_W-1:0] rNext, gNext, bNext;

    always_comb begin
        rNext = '0;
        gNext = '0;
        bNext = '0;
        if (flagsOut.act) begin
            rNext = pix.iRed;
            gNext = pix.iGreen;
            bNext = pix.iBlue;
`ifdef VGA_SCAN_CURSOR_EN
            if (cursorOut) begin
                rNext = iCursor_R;
                gNext = iCursor_G;
                bNext = iCursor_B;
            end
`endif
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oVGA_R       <= '0;
            oVGA_G       <= '0;
            oVGA_B       <= '0;
            oVGA_H_SYNC  <= ~SYNC_POL;
            oVGA_V_SYNC  <= ~SYNC_POL;
            oVGA_BLANK   <= 1'b0;
            oLine_Start  <= 1'b0;
            oFrame_Start <= 1'b0;
        end else begin
            oVGA_R       <= rNext;
            oVGA_G       <= gNext;
            oVGA_B       <= bNext;
            oVGA_H_SYNC  <= flagsOut.hSync ? SYNC_POL : ~SYNC_POL;
            oVGA_V_SYNC  <= flagsOut.vSync ? SYNC_POL : ~SYNC_POL;
            oVGA_BLANK   <= flagsOut.act;
            oLine_Start  <= (hCont == '0);
            oFrame_Start <= (hCont == '0) && (vCont == '0);
        end
    end

endmodule

// File: tb/tb_vga_scan_engine.sv
module tb_vga_scan_engine;

    localparam int CW = 4;
    localparam int HS = 2, HB = 2, HA = 8, HF = 2;
    localparam int VS = 1, VB = 1, VA = 4, VF = 1;
    localparam int HT = HS + HB + HA + HF;   // 14
    localparam int VT = VS + VB + VA + VF;   // 7
    localparam int LAT0 = 2, LAT1 = 3;

    localparam int CUR_X = 3, CUR_Y = 1;
    localparam logic [3:0] CUR_R = 4'hF, CUR_G = 4'h2, CUR_B = 4'h3;
`ifdef VGA_SCAN_CURSOR_EN
    localparam bit CUR_ON = 1'b1;
`else
    localparam bit CUR_ON = 1'b0;
`endif

    typedef struct packed { logic req; logic [9:0] x; logic [9:0] y; logic [19:0] addr; } fexp_t;
    typedef struct packed { logic [3:0] r; logic [3:0] g; logic [3:0] b; logic hs; logic vs; logic bl; } pexp_t;
    typedef struct packed { logic ls; logic fs; } sexp_t;
    typedef struct packed { logic req; logic [9:0] x; logic [9:0] y; } hist_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vga_scan_engine_if #(.COLOR_W(CW)) pif0 ();
    vga_scan_engine_if #(.COLOR_W(CW)) pif1 ();

    logic [CW-1:0] r0, g0, b0, r1, g1, b1;
    logic hs0, vs0, bl0, fs0, ls0, hs1, vs1, bl1, fs1, ls1;

`ifdef VGA_SCAN_CURSOR_EN
    logic          curEn0 = 1'b1, curEn1 = 1'b0;
    logic [9:0]    curX = 10'(CUR_X), curY = 10'(CUR_Y);
    logic [CW-1:0] curR = CUR_R, curG = CUR_G, curB = CUR_B;
`endif

    vga_scan_engine #(
        .COLOR_W(CW), .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
        .SYNC_POL(1'b0), .PIX_LAT(LAT0), .SCALE_SHIFT(0)
    ) dut0 (
        .iCLK(clk), .iRST_N(rst_n), .pix(pif0.master),
`ifdef VGA_SCAN_CURSOR_EN
        .iCursor_EN(curEn0), .iCursor_X(curX), .iCursor_Y(curY),
        .iCursor_R(curR), .iCursor_G(curG), .iCursor_B(curB),
`endif
        .oVGA_R(r0), .oVGA_G(g0), .oVGA_B(b0),
        .oVGA_H_SYNC(hs0), .oVGA_V_SYNC(vs0), .oVGA_BLANK(bl0),
        .oFrame_Start(fs0), .oLine_Start(ls0)
    );

    vga_scan_engine #(
        .COLOR_W(CW), .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
        .SYNC_POL(1'b1), .PIX_LAT(LAT1), .SCALE_SHIFT(1)
    ) dut1 (
        .iCLK(clk), .iRST_N(rst_n), .pix(pif1.master),
`ifdef VGA_SCAN_CURSOR_EN
        .iCursor_EN(curEn1), .iCursor_X(curX), .iCursor_Y(curY),
        .iCursor_R(curR), .iCursor_G(curG), .iCursor_B(curB),
`endif
        .oVGA_R(r1), .oVGA_G(g1), .oVGA_B(b1),
        .oVGA_H_SYNC(hs1), .oVGA_V_SYNC(vs1), .oVGA_BLANK(bl1),
        .oFrame_Start(fs1), .oLine_Start(ls1)
    );

    int nChecks = 0;
    int nFails  = 0;
    int hc, vc;

    fexp_t qF0[$], qF1[$];
    pexp_t qP0[$], qP1[$];
    sexp_t qS0[$], qS1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Expected pins for counter state (hc, vc) of one engine configuration.
    function automatic void model(input int h, input int v, input int ss, input bit pol,
                                  input bit cur, output fexp_t f, output pexp_t p, output sexp_t s);
        bit act, hit;
        int x, y;
        act = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
        x   = act ? (h - (HS + HB)) >> ss : 0;
        y   = act ? (v - (VS + VB)) >> ss : 0;
        hit = cur && act && ((x >= CUR_X - 1 && x <= CUR_X + 1) || (y >= CUR_Y - 1 && y <= CUR_Y + 1));
        f.req  = act;
        f.x    = 10'(x);
        f.y    = 10'(y);
        f.addr = 20'(y * (HA >> ss) + x);
        p.r  = !act ? 4'h0 : hit ? CUR_R : 4'(x + 1);
        p.g  = !act ? 4'h0 : hit ? CUR_G : 4'(y + 1);
        p.b  = !act ? 4'h0 : hit ? CUR_B : 4'(x ^ 5);
        p.bl = act;
        p.hs = (h < HS) ? pol : !pol;
        p.vs = (v < VS) ? pol : !pol;
        s.ls = (h == 0);
        s.fs = (h == 0) && (v == 0);
    endfunction

    task automatic pushAll();
        fexp_t f; pexp_t p; sexp_t s;
        model(hc, vc, 0, 1'b0, CUR_ON, f, p, s);
        qF0.push_back(f); qP0.push_back(p); qS0.push_back(s);
        model(hc, vc, 1, 1'b1, 1'b0, f, p, s);
        qF1.push_back(f); qP1.push_back(p); qS1.push_back(s);
    endtask

    task automatic clearQueues();
        qF0.delete(); qP0.delete(); qS0.delete();
        qF1.delete(); qP1.delete(); qS1.delete();
    endtask

    task automatic step();
        pushAll();
        @(negedge clk);
        hc++;
        if (hc == HT) begin
            hc = 0;
            vc++;
            if (vc == VT) vc = 0;
        end
    endtask

    task automatic checkReset(input string tag);
        chk({tag, ".d0.r"}, r0, 0);   chk({tag, ".d0.g"}, g0, 0);   chk({tag, ".d0.b"}, b0, 0);
        chk({tag, ".d0.hs"}, hs0, 1); chk({tag, ".d0.vs"}, vs0, 1); chk({tag, ".d0.bl"}, bl0, 0);
        chk({tag, ".d0.req"}, pif0.oReq, 0);
        chk({tag, ".d0.ls"}, ls0, 0); chk({tag, ".d0.fs"}, fs0, 0);
        chk({tag, ".d1.r"}, r1, 0);   chk({tag, ".d1.g"}, g1, 0);   chk({tag, ".d1.b"}, b1, 0);
        chk({tag, ".d1.hs"}, hs1, 0); chk({tag, ".d1.vs"}, vs1, 0); chk({tag, ".d1.bl"}, bl1, 0);
        chk({tag, ".d1.req"}, pif1.oReq, 0);
        chk({tag, ".d1.ls"}, ls1, 0); chk({tag, ".d1.fs"}, fs1, 0);
    endtask

    // Pixel source: returns data for each request exactly PIX_LAT clocks
    // later; between requests it drives all-ones, which must never reach
    // the pins.
    initial begin
        hist_t h0 [0:3];
        hist_t h1 [0:3];
        for (int i = 0; i < 4; i++) begin h0[i] = '0; h1[i] = '0; end
        pif0.iRed = '0; pif0.iGreen = '0; pif0.iBlue = '0;
        pif1.iRed = '0; pif1.iGreen = '0; pif1.iBlue = '0;
        forever begin
            @(negedge clk);
            for (int i = 3; i > 0; i--) begin h0[i] = h0[i-1]; h1[i] = h1[i-1]; end
            h0[0] = '{pif0.oReq, pif0.oCoord_X, pif0.oCoord_Y};
            h1[0] = '{pif1.oReq, pif1.oCoord_X, pif1.oCoord_Y};
            pif0.iRed   = h0[LAT0].req ? 4'(h0[LAT0].x + 1) : 4'hF;
            pif0.iGreen = h0[LAT0].req ? 4'(h0[LAT0].y + 1) : 4'hF;
            pif0.iBlue  = h0[LAT0].req ? 4'(h0[LAT0].x ^ 5) : 4'hF;
            pif1.iRed   = h1[LAT1].req ? 4'(h1[LAT1].x + 1) : 4'hF;
            pif1.iGreen = h1[LAT1].req ? 4'(h1[LAT1].y + 1) : 4'hF;
            pif1.iBlue  = h1[LAT1].req ? 4'(h1[LAT1].x ^ 5) : 4'hF;
        end
    end

    // Monitor: fetch bus is compared in the cycle it was predicted for,
    // pulses one clock later, video pins PIX_LAT+1 clocks later.
    initial begin
        fexp_t f; pexp_t p; sexp_t s;
        forever begin
            @(negedge clk);
            #1;
            if (qF0.size() >= 1) begin
                f = qF0.pop_front();
                chk("d0.req", pif0.oReq, f.req);
                if (f.req) begin
                    chk("d0.x", pif0.oCoord_X, f.x); chk("d0.y", pif0.oCoord_Y, f.y);
                    chk("d0.addr", pif0.oAddress, f.addr);
                end
            end
            if (qF1.size() >= 1) begin
                f = qF1.pop_front();
                chk("d1.req", pif1.oReq, f.req);
                if (f.req) begin
                    chk("d1.x", pif1.oCoord_X, f.x); chk("d1.y", pif1.oCoord_Y, f.y);
                    chk("d1.addr", pif1.oAddress, f.addr);
                end
            end
            if (qS0.size() >= 2) begin
                s = qS0.pop_front();
                chk("d0.line_start", ls0, s.ls); chk("d0.frame_start", fs0, s.fs);
            end
            if (qS1.size() >= 2) begin
                s = qS1.pop_front();
                chk("d1.line_start", ls1, s.ls); chk("d1.frame_start", fs1, s.fs);
            end
            if (qP0.size() >= LAT0 + 2) begin
                p = qP0.pop_front();
                chk("d0.r", r0, p.r); chk("d0.g", g0, p.g); chk("d0.b", b0, p.b);
                chk("d0.hs", hs0, p.hs); chk("d0.vs", vs0, p.vs); chk("d0.blank", bl0, p.bl);
            end
            if (qP1.size() >= LAT1 + 2) begin
                p = qP1.pop_front();
                chk("d1.r", r1, p.r); chk("d1.g", g1, p.g); chk("d1.b", b1, p.b);
                chk("d1.hs", hs1, p.hs); chk("d1.vs", vs1, p.vs); chk("d1.blank", bl1, p.bl);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        hc = 0;
        vc = 0;
        repeat (3) begin
            @(negedge clk);
            #2 checkReset("por");
        end

        // Release; this cycle is H_Cont=V_Cont=0.
        @(negedge clk);
        rst_n = 1'b1;
        hc = 0;
        vc = 0;
        step();
        chk("d0.first_frame_start", fs0, 1);
        chk("d1.first_frame_start", fs1, 1);
        repeat (2 * HT * VT - 1) step();

        // Mid-frame reset at H_Cont=5, V_Cont=2, held for 3 clocks.
        while (!(hc == 5 && vc == 2)) step();
        rst_n = 1'b0;
        clearQueues();
        #2 checkReset("mid");
        repeat (2) begin
            @(negedge clk);
            #2 checkReset("mid");
        end
        @(negedge clk);
        rst_n = 1'b1;
        hc = 0;
        vc = 0;
        step();
        chk("d0.frame_start_after_rst", fs0, 1);
        chk("d1.frame_start_after_rst", fs1, 1);
        chk("d0.line_start_after_rst", ls0, 1);
        repeat (HT * VT + 20) step();

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/vga_scan_engine.md
VGA_SCAN_ENGINE -- requirements
Module: vga_scan_engine

Interface
- REQ-001 Parameter COLOR_W, default 4: bits per colour channel.
- REQ-002 Parameters H_SYNC/H_BP/H_ACT/H_FP, defaults 96/48/640/16: horizontal phase lengths in pixel clocks.
- REQ-003 Parameters V_SYNC/V_BP/V_ACT/V_FP, defaults 2/33/480/10: vertical phase lengths in lines.
- REQ-004 Parameter SYNC_POL, default 0: asserted level of both syncs.
- REQ-005 Parameter PIX_LAT, default 2, range 1..8: clocks from oReq to iRed/iGreen/iBlue valid.
- REQ-006 Parameter SCALE_SHIFT, default 0, range 0..2: each source pixel and line is replicated 2^SCALE_SHIFT times.
- REQ-007 iCLK  in  1  pixel clock; the block uses this single clock.
- REQ-008 iRST_N  in  1  asynchronous, active-low reset.
- REQ-009 iRed/iGreen/iBlue  in  COLOR_W each  pixel data, PIX_LAT clocks after oReq.
- REQ-010 oReq  out  1  pixel fetch request for oCoord_X/oCoord_Y/oAddress.
- REQ-011 oCoord_X/oCoord_Y  out  10 each  scaled source coordinates.
- REQ-012 oAddress  out  20  oCoord_Y*(H_ACT>>SCALE_SHIFT)+oCoord_X.
- REQ-013 oVGA_R/oVGA_G/oVGA_B  out  COLOR_W each  registered colour; zero outside active.
- REQ-014 oVGA_H_SYNC/oVGA_V_SYNC/oVGA_BLANK  out  1 each  syncs; BLANK is low while not active.
- REQ-015 oFrame_Start/oLine_Start  out  1 each  single-cycle pulses.

Function
- REQ-016 H_Cont SHALL count 0..H_TOTAL-1 (H_TOTAL=H_SYNC+H_BP+H_ACT+H_FP) and wrap to 0; V_Cont SHALL increment when H_Cont wraps and wrap after V_TOTAL-1.
- REQ-017 Phase order per axis SHALL be sync, back porch, active, front porch; active X window is [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT).
- REQ-018 oReq SHALL be high exactly on cycles where both counters are in their active windows; oCoord/oAddress SHALL be valid combinationally with oReq.
- REQ-019 oCoord_X = (H_Cont-X_START)>>SCALE_SHIFT; oCoord_Y = (V_Cont-Y_START)>>SCALE_SHIFT; oAddress computed without truncation below 20 bits.
- REQ-020 Active, sync and blank flags SHALL pass through a PIX_LAT-deep delay line so outputs align with returned data; colour register captures iRGB when delayed active, else 0.
- REQ-021 Total latency counter-to-pin SHALL be PIX_LAT+1 clocks for syncs, blank and colour alike.
- REQ-022 oLine_Start pulses when H_Cont==0; oFrame_Start pulses when H_Cont==0 and V_Cont==0 (same-cycle coincidence: both high).
- REQ-023 Outputs SHALL not be gated by iRGB values; no backpressure exists; late data is the source's fault.

Reset
- REQ-024 On iRST_N low: counters 0, delay lines cleared, oVGA_R/G/B 0, syncs deasserted (~SYNC_POL), oVGA_BLANK low, oReq/pulses 0.
- REQ-025 Reset mid-frame SHALL restart at H_Cont=V_Cont=0; first oFrame_Start one clock after release.

Configuration
- REQ-026 Macro VGA_SCAN_CURSOR_EN: when defined, ports iCursor_EN(1), iCursor_X/iCursor_Y(10), iCursor_R/G/B(COLOR_W) exist and a 3-pixel-wide crosshair (cursor ±1 in scaled coords) replaces colour, aligned through the delay line; when undefined those ports and logic are absent and colour is pure pass-through.

Structure
- REQ-027 Package vga_pkg SHALL hold default 640x480 timing constants, phase enum (SYNC, BP, ACT, FP) and the COLOR_W default.
- REQ-028 One sub-module vga_axis_counter (count, wrap, phase decode, advance enable) SHALL be instantiated twice, horizontal and vertical.

Verification
- REQ-029 Small timing H 2/2/8/2, V 1/1/4/1, PIX_LAT=2: oReq high 8 clocks per active line, first at H_Cont=4; H_SYNC asserted H_Cont 0..1 seen at pins clocks 3..4.
- REQ-030 iRed=oCoord_X+1 returned after 2 clocks -> oVGA_R sequence 1..8 per line, zero in porches.
- REQ-031 SCALE_SHIFT=1, H_ACT=8, V_ACT=4: oCoord_X 0,0,1,1,2,2,3,3; oAddress row 1 starts at 4.
- REQ-032 Assert iRST_N low at H_Cont=5, V_Cont=2 for 3 clocks -> all outputs reset values; oFrame_Start one clock after release.
- REQ-033 Cursor macro on, iCursor_X=3, iCursor_Y=1, iCursor_R=F -> oVGA_R=F at coords X 2..4 every line, all of row 0..2.
- REQ-034 SYNC_POL=1 -> syncs idle low, pulse high, same widths as REQ-029.
